// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Parametrised integer register file with NREAD asynchronous read
//            ports, an optional writeback-to-read bypass and a per-register
//            busy scoreboard for reserving pending destinations.
// Ports    : clk, rst_n (sync, active low)
//            i_re, i_rs        -> o_read_data, o_rs_busy   (operand fetch)
//            i_issue, i_issue_rd -> o_issue_ok             (reserve dest)
//            i_wr, i_rd, i_write_data                      (writeback)
//            o_busy_count                                  (popcount of busy)
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_re,
    input  logic [NREAD*$clog2(NREGS)-1:0] i_rs,
    output logic [NREAD*XLEN-1:0]         o_read_data,
    output logic [NREAD-1:0]              o_rs_busy,
    input  logic                          i_issue,
    input  logic [$clog2(NREGS)-1:0]      i_issue_rd,
    output logic                          o_issue_ok,
    input  logic                          i_wr,
    input  logic [$clog2(NREGS)-1:0]      i_rd,
    input  logic [XLEN-1:0]               i_write_data,
    output logic [$clog2(NREGS):0]        o_busy_count
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  w_reg_view [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;
    logic [AW:0]      r_busy_count;
    logic             w_wr_valid;
    logic             w_wr_hits_issue;
    logic             w_set;
    logic             w_inc;
    logic             w_dec;

    // A writeback only counts when out of reset and not aimed at x0.
    assign w_wr_valid      = i_wr & rst_n & (i_rd != '0);
    assign w_wr_hits_issue = w_wr_valid & (i_rd == i_issue_rd);

    // A busy destination may be re-reserved only in the cycle it is released.
    assign o_issue_ok = i_issue & rst_n &
                        ((i_issue_rd == '0) | ~r_busy[i_issue_rd] | w_wr_hits_issue);
    assign w_set      = o_issue_ok & (i_issue_rd != '0);

    // Count deltas: a release and re-reserve of the same busy register cancel.
    assign w_inc = w_set & ~r_busy[i_issue_rd];
    assign w_dec = w_wr_valid & r_busy[i_rd] & ~(w_set & (i_issue_rd == i_rd));

    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_valid) begin
            w_busy_next[i_rd] = 1'b0;
        end
        // Set after clear so a simultaneous new producer wins.
        if (w_set) begin
            w_busy_next[i_issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= r_busy_count + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end

    assign o_busy_count = r_busy_count;

    // x0 has no storage; its view is hard-wired to zero.
    assign w_reg_view[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_regs
        logic [XLEN-1:0] r_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_wr_valid && (i_rd == AW'(i))) begin
                r_q <= i_write_data;
            end
        end
        assign w_reg_view[i] = r_q;
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] w_rs;
        logic          w_hit;
        assign w_rs  = i_rs[k*AW +: AW];
        assign w_hit = (BYPASS != 0) & w_wr_valid & (i_rd == w_rs);

        assign o_read_data[k*XLEN +: XLEN] =
            (!i_re || (w_rs == '0)) ? '0 :
            w_hit                   ? i_write_data :
                                      w_reg_view[w_rs];

        // Busy status ignores i_re; a same-cycle release reads as not busy.
        assign o_rs_busy[k] = (w_rs != '0) & ~w_hit & r_busy[w_rs];
    end

endmodule
`default_nettype wire
